// File: rtl/frame_rx_controller_pkg.sv
// Shared types and frame geometry for the serial frame receiver.
package frame_rx_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECEIVE = 2'd1,
        ST_HOLD    = 2'd2
    } rx_state_t;

    localparam int FRAME_BITS = 11;
    localparam int DATA_BITS  = 8;

    // Bit-counter values at which the parity and stop bits are sampled
    localparam logic [3:0] STOP_BIT_INDEX   = 4'(FRAME_BITS - 1);
    localparam logic [3:0] PARITY_BIT_INDEX = 4'(FRAME_BITS - 2);

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-stage synchronizer for an asynchronous line plus a falling-edge pulse.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_async,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Line idles high, so the chain and edge history reset to 1
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync <= '1;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_fall = r_prev & ~r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/frame_rx_controller.sv
// Receives 11-bit start/data/parity/stop frames sampled on serial clock falling edges.
// Optional odd-parity checking is enabled by defining FRAME_RX_PARITY_CHECK_EN.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | waiting for a falling edge with data 0 (start bit)
// ST_RECEIVE | shifting data, parity and stop bits; idle-cycle timeout armed
// ST_HOLD    | frame presented on outputs until the consumer acknowledges
module frame_rx_controller
    import frame_rx_controller_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000,
    parameter int          SYNC_STAGES    = 2
) (
    input  logic                 i_control_clock,
    input  logic                 i_reset,
    input  logic                 i_serial_clock,
    input  logic                 i_debounced_data,
    input  logic                 i_frame_ack,
    output logic [DATA_BITS-1:0] o_parallel_data_output,
    output logic                 o_frame_valid,
    output logic                 o_parity_error,
    output logic                 o_frame_error,
    output logic                 o_overrun,
    output logic                 o_busy
);

    logic                   w_fall;
    logic                   w_data;
    logic [SYNC_STAGES-1:0] r_data_sync;

    rx_state_t              r_state;
    rx_state_t              w_state_next;
    logic [3:0]             r_bit_cnt;
    logic [15:0]            r_timer;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]   r_data_out;
    logic                   r_valid;
    logic                   r_frame_err;
    logic                   r_overrun;

    logic w_start;
    logic w_shift;
    logic w_accept;
    logic w_discard;
    logic w_timer_tick;
    logic w_ack;
    logic w_drop;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sclk_edge (
        .i_clk   (i_control_clock),
        .i_reset (i_reset),
        .i_async (i_serial_clock),
        .o_fall  (w_fall)
    );

    // Same depth as the clock chain so data lines up with the detected edge
    always_ff @(posedge i_control_clock) begin
        if (i_reset) begin
            r_data_sync <= '1;
        end else begin
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], i_debounced_data};
        end
    end

    assign w_data = r_data_sync[SYNC_STAGES-1];

    always_ff @(posedge i_control_clock) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_shift      = 1'b0;
        w_accept     = 1'b0;
        w_discard    = 1'b0;
        w_timer_tick = 1'b0;
        w_ack        = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_fall && !w_data) begin
                    w_state_next = ST_RECEIVE;
                    w_start      = 1'b1;
                end
            end
            ST_RECEIVE: begin
                // An edge always beats a coincident timeout
                if (w_fall) begin
                    if (r_bit_cnt == STOP_BIT_INDEX) begin
                        if (w_data) begin
                            w_state_next = ST_HOLD;
                            w_accept     = 1'b1;
                        end else begin
                            w_state_next = ST_IDLE;
                            w_discard    = 1'b1;
                        end
                    end else if (r_bit_cnt < PARITY_BIT_INDEX) begin
                        w_shift = 1'b1;
                    end
                end else if (r_timer <= 16'd1) begin
                    w_state_next = ST_IDLE;
                    w_discard    = 1'b1;
                end else begin
                    w_timer_tick = 1'b1;
                end
            end
            ST_HOLD: begin
                if (i_frame_ack) begin
                    w_state_next = ST_IDLE;
                    w_ack        = 1'b1;
                end else if (w_fall && !w_data) begin
                    w_drop = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_control_clock) begin
        if (i_reset) begin
            r_bit_cnt   <= '0;
            r_timer     <= '0;
            r_shift     <= '0;
            r_data_out  <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_discard;

            if (w_state_next != ST_RECEIVE) begin
                r_bit_cnt <= '0;
            end else if (w_start) begin
                r_bit_cnt <= 4'd1;
            end else if (w_fall) begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end

            // Down-counter reloaded on every edge; terminal count ends the frame
            if (w_state_next != ST_RECEIVE) begin
                r_timer <= '0;
            end else if (w_fall) begin
                r_timer <= TIMEOUT_CYCLES - 16'd1;
            end else if (w_timer_tick) begin
                r_timer <= r_timer - 16'd1;
            end

            if (w_start) begin
                r_shift <= '0;
            end else if (w_shift) begin
                r_shift <= {w_data, r_shift[DATA_BITS-1:1]};
            end

            if (w_accept) begin
                r_data_out <= r_shift;
                r_valid    <= 1'b1;
            end else if (w_ack) begin
                r_valid <= 1'b0;
            end

            if (w_ack) begin
                r_overrun <= 1'b0;
            end else if (w_drop) begin
                r_overrun <= 1'b1;
            end
        end
    end

`ifdef FRAME_RX_PARITY_CHECK_EN
    logic r_parity_bit;
    logic r_parity_err;

    always_ff @(posedge i_control_clock) begin
        if (i_reset) begin
            r_parity_bit <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            if (w_fall && (r_state == ST_RECEIVE) && (r_bit_cnt == PARITY_BIT_INDEX)) begin
                r_parity_bit <= w_data;
            end
            if (w_accept) begin
                r_parity_err <= ~(^{r_shift, r_parity_bit});
            end
        end
    end

    assign o_parity_error = r_parity_err;
`else
    assign o_parity_error = 1'b0;
`endif

    assign o_parallel_data_output = r_data_out;
    assign o_frame_valid          = r_valid;
    assign o_frame_error          = r_frame_err;
    assign o_overrun              = r_overrun;
    assign o_busy                 = (r_state == ST_RECEIVE);

endmodule

// File: tb/tb_frame_rx_controller.sv
// Bench for frame_rx_controller: directed scenarios plus random frames against a frame-level model.
module tb_frame_rx_controller;

    localparam int          SYNC = 2;
    localparam logic [15:0] TMO  = 16'd100;
`ifdef FRAME_RX_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk;
    logic       sdata;
    logic       ack;
    logic [7:0] dout;
    logic       valid;
    logic       perr;
    logic       ferr;
    logic       ovr;
    logic       busy;

    frame_rx_controller #(
        .TIMEOUT_CYCLES (TMO),
        .SYNC_STAGES    (SYNC)
    ) dut (
        .i_control_clock        (clk),
        .i_reset                (rst),
        .i_serial_clock         (sclk),
        .i_debounced_data       (sdata),
        .i_frame_ack            (ack),
        .o_parallel_data_output (dout),
        .o_frame_valid          (valid),
        .o_parity_error         (perr),
        .o_frame_error          (ferr),
        .o_overrun              (ovr),
        .o_busy                 (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Observation state, updated once per cycle
    int cyc = 0;
    int fe_count = 0;
    int fe_run = 0;
    int fe_max_run = 0;
    int t_last_fall = 0;
    int t_valid_rise = -1;
    int t_fe_rise = -1;
    bit prev_valid = 1'b0;
    bit prev_fe = 1'b0;

    // Frame-level reference model
    bit         m_valid = 1'b0;
    logic [7:0] m_data  = 8'h00;
    bit         m_perr  = 1'b0;
    bit         m_ovr   = 1'b0;
    int         m_fe    = 0;

    logic [7:0] d;
    bit         par;
    bit         stop;
    bit         held;
    bit         good_p;
    int         guard;
    int         target;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
        end
    endtask

    task step;
        @(posedge clk);
        #1;
        cyc++;
        if (ferr) begin
            fe_count++;
            fe_run++;
            if (fe_run > fe_max_run) fe_max_run = fe_run;
        end else begin
            fe_run = 0;
        end
        if (valid && !prev_valid) t_valid_rise = cyc;
        if (ferr && !prev_fe) t_fe_rise = cyc;
        prev_valid = valid;
        prev_fe    = ferr;
    endtask

    task idle(input int n);
        sclk = 1'b1;
        sdata = 1'b1;
        repeat (n) step();
    endtask

    task send_bit(input bit b, input int lo);
        sdata = b;
        sclk  = 1'b1;
        repeat ($urandom_range(1, 4)) step();
        sclk = 1'b0;
        t_last_fall = cyc;
        repeat (lo) step();
    endtask

    task send_frame(input logic [7:0] fd, input bit fp, input bit fs, input int tail);
        send_bit(1'b0, $urandom_range(1, 4));
        for (int i = 0; i < 8; i++) send_bit(fd[i], $urandom_range(1, 4));
        send_bit(fp, $urandom_range(1, 4));
        send_bit(fs, tail);
    endtask

    function automatic bit odd_par(input logic [7:0] fd);
        return ($countones(fd) % 2) == 0;
    endfunction

    task model_frame(input logic [7:0] fd, input bit fp, input bit fs);
        if (m_valid) begin
            m_ovr = 1'b1;
        end else if (fs) begin
            m_valid = 1'b1;
            m_data  = fd;
            m_perr  = PAR_EN && ((($countones(fd) + int'(fp)) % 2) == 0);
        end else begin
            m_fe++;
        end
    endtask

    task do_ack;
        ack = 1'b1;
        step();
        ack = 1'b0;
        if (m_valid) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
    endtask

    task compare_all(input string tag);
        check_val({tag, "_valid"}, 32'(valid), 32'(m_valid));
        check_val({tag, "_data"}, 32'(dout), 32'(m_data));
        check_val({tag, "_perr"}, 32'(perr), 32'(m_perr));
        check_val({tag, "_ovr"}, 32'(ovr), 32'(m_ovr));
        check_val({tag, "_busy"}, 32'(busy), 32'd0);
        check_val({tag, "_fe_cnt"}, 32'(fe_count), 32'(m_fe));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; sclk = 1'b1; sdata = 1'b1; ack = 1'b0;
        repeat (4) step();
        compare_all("reset");
        check_val("reset_ferr", 32'(ferr), 32'd0);
        rst = 1'b0;
        idle(3);

        // Good frame 0x5A with correct odd parity
        t_valid_rise = -1;
        send_frame(8'h5A, 1'b1, 1'b1, $urandom_range(1, 4));
        idle(6);
        model_frame(8'h5A, 1'b1, 1'b1);
        compare_all("f5a");
        check_val("f5a_lat", 32'(t_valid_rise - t_last_fall), 32'(SYNC + 1));
        do_ack();
        compare_all("f5a_ack");

        // Bad parity, acknowledged in the very cycle FRAME_VALID rises
        t_valid_rise = -1;
        send_frame(8'h5A, 1'b0, 1'b1, 1);
        check_val("f5b_early", 32'(valid), 32'd0);
        guard = 0;
        while (!valid && guard < 20) begin
            step();
            guard++;
        end
        check_val("f5b_seen", 32'(valid), 32'd1);
        check_val("f5b_lat", 32'(t_valid_rise - t_last_fall), 32'(SYNC + 1));
        check_val("f5b_perr", 32'(perr), 32'(PAR_EN));
        check_val("f5b_data", 32'(dout), 32'h5A);
        model_frame(8'h5A, 1'b0, 1'b1);
        do_ack();
        check_val("f5b_ack_valid", 32'(valid), 32'd0);
        idle(4);
        compare_all("f5b");

        // Bad stop bit
        t_fe_rise = -1;
        send_frame(8'h3C, odd_par(8'h3C), 1'b0, $urandom_range(1, 4));
        idle(6);
        model_frame(8'h3C, odd_par(8'h3C), 1'b0);
        compare_all("f3c");
        check_val("f3c_fe_lat", 32'(t_fe_rise - t_last_fall), 32'(SYNC + 1));

        // Start + 5 data bits, then the serial clock stalls high
        d = 8'h15;
        send_bit(1'b0, $urandom_range(1, 4));
        for (int i = 0; i < 5; i++) send_bit(d[i], (i == 4) ? 1 : $urandom_range(1, 4));
        idle(0);
        target = t_last_fall + SYNC + int'(TMO);
        while (cyc < target - 1) step();
        check_val("tmo_busy_before", 32'(busy), 32'd1);
        check_val("tmo_fe_before", 32'(ferr), 32'd0);
        step();
        check_val("tmo_fe", 32'(ferr), 32'd1);
        check_val("tmo_busy_after", 32'(busy), 32'd0);
        m_fe++;
        step();
        check_val("tmo_fe_end", 32'(ferr), 32'd0);
        send_frame(8'hA5, odd_par(8'hA5), 1'b1, $urandom_range(1, 4));
        idle(6);
        model_frame(8'hA5, odd_par(8'hA5), 1'b1);
        compare_all("fa5");
        do_ack();

        // Overrun: hold 0x11, send 0x22 without acknowledging
        send_frame(8'h11, odd_par(8'h11), 1'b1, $urandom_range(1, 4));
        idle(6);
        model_frame(8'h11, odd_par(8'h11), 1'b1);
        compare_all("f11");
        send_frame(8'h22, odd_par(8'h22), 1'b1, $urandom_range(1, 4));
        idle(6);
        model_frame(8'h22, odd_par(8'h22), 1'b1);
        compare_all("f22_ovr");
        do_ack();
        compare_all("ovr_ack");

        // Reset after four data bits
        d = 8'h6B;
        send_bit(1'b0, $urandom_range(1, 4));
        for (int i = 0; i < 4; i++) send_bit(d[i], $urandom_range(1, 4));
        sclk = 1'b1; sdata = 1'b1; rst = 1'b1;
        step();
        step();
        m_valid = 1'b0; m_data = 8'h00; m_perr = 1'b0; m_ovr = 1'b0;
        compare_all("rst_mid");
        rst = 1'b0;
        idle(4);
        compare_all("rst_rel");
        t_valid_rise = -1;
        send_frame(8'h81, odd_par(8'h81), 1'b1, $urandom_range(1, 4));
        idle(6);
        model_frame(8'h81, odd_par(8'h81), 1'b1);
        compare_all("f81");
        check_val("f81_lat", 32'(t_valid_rise - t_last_fall), 32'(SYNC + 1));
        do_ack();

        // Random frames
        for (int n = 0; n < 40; n++) begin
            d      = 8'($urandom);
            good_p = odd_par(d);
            par    = ($urandom_range(0, 3) == 0) ? !good_p : good_p;
            stop   = ($urandom_range(0, 7) != 0);
            held   = m_valid;
            t_valid_rise = -1;
            t_fe_rise    = -1;
            send_frame(d, par, stop, $urandom_range(1, 4));
            idle(6);
            model_frame(d, par, stop);
            compare_all("rnd");
            if (!held && stop) check_val("rnd_lat", 32'(t_valid_rise - t_last_fall), 32'(SYNC + 1));
            if (!held && !stop) check_val("rnd_fe_lat", 32'(t_fe_rise - t_last_fall), 32'(SYNC + 1));
            if ($urandom_range(0, 9) < 7) begin
                idle($urandom_range(0, 3));
                do_ack();
                compare_all("rnd_ack");
            end
        end

        check_val("fe_pulse_width", 32'(fe_max_run), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
